image_stream_src: RTL
=====================

Name: image_stream_src

Overview:
- Parametrised, backpressure-aware pixel source for the image-processing chain.
- Fetches a bottom-up BMP-ordered RGB frame from an external synchronous memory, PPC pixels per word.
- Applies a run-time selectable point operation: passthrough, brightness +/-, invert, or threshold.
- Streams the result with a valid/ready handshake plus VSYNC/HSYNC framing, feeding the BMP writer or further filters.

Parameters:
- WIDTH, 768, pixels per line; must be a multiple of PPC.
- HEIGHT, 512, lines per frame.
- PPC, 2, pixels per clock/word; legal values 1, 2, 4.
- START_UP_DELAY, 100, VSYNC state length in cycles; must be >= 1.
- HSYNC_DELAY, 160, gap before each line in cycles; must be >= 1.
- ADDR_W, 20, word-address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT/PPC.

Ports:
- HCLK, in, 1: clock; all logic on the rising edge.
- HRESETn, in, 1: reset, synchronous, active-low.
- start, in, 1: frame request pulse; ignored while busy=1.
- mode, in, 3: 0 pass, 1 bright add, 2 bright sub, 3 invert, 4 threshold, 5-7 pass. Latched on an accepted start.
- value, in, 8: brightness offset; latched on an accepted start.
- threshold, in, 8: threshold level; latched on an accepted start.
- mem_rd, out, 1: read strobe.
- mem_addr, out, ADDR_W: word address.
- mem_rdata, in, PPC*24: read data, valid exactly 1 cycle after mem_rd. Pixel p occupies bits [24p+23:24p] = {R,G,B}.
- out_valid, out, 1: out_data is valid.
- out_ready, in, 1: sink accepts data.
- out_data, out, PPC*24: processed pixels, same packing as mem_rdata.
- out_sol, out, 1: out_data carries the first word of a line.
- out_eol, out, 1: out_data carries the last word of a line.
- VSYNC, out, 1: high throughout the VSYNC state.
- HSYNC, out, 1: equal to out_valid (line data active).
- busy, out, 1: state != IDLE.
- ctrl_done, out, 1: one-cycle pulse after the last word of the frame is accepted.

Behaviour:
- Reset: state IDLE; all counters 0; buffer empty; in-flight read discarded. All outputs 0: out_data=0, mem_addr=0, mem_rd=0, VSYNC=0, HSYNC=0, ctrl_done=0, busy=0. Applies identically mid-frame.
- FSM states IDLE, VSYNC, HSYNC, DATA, DRAIN.
  - IDLE -> VSYNC on start; mode, value and threshold are latched in the same cycle.
  - VSYNC lasts exactly START_UP_DELAY cycles, then -> HSYNC.
  - HSYNC lasts exactly HSYNC_DELAY cycles, then -> DATA.
  - DATA issues WIDTH/PPC reads for the current line. After the last read: -> HSYNC if lines remain, else -> DRAIN.
  - DRAIN: when the buffer is empty and no read is in flight, pulse ctrl_done for 1 cycle and -> IDLE.
- Addressing: line r (0 = first output line), word c gives mem_addr = (HEIGHT-1-r)*(WIDTH/PPC) + c. Rows are output top-down from bottom-up storage.
- Read issue: in DATA, mem_rd=1 only when (buffer occupancy + reads in flight) < 2. The 2-entry output buffer ensures no data loss under any out_ready pattern.
- Pipeline: mem_rdata is captured 1 cycle after mem_rd, processed combinationally, and written into the buffer. With out_ready=1, out_valid rises 2 cycles after the first mem_rd of a line.
- Sustained throughput is 1 word/cycle while out_ready=1.
- Handshake: a transfer occurs when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_sol and out_eol are held stable.
  - out_valid never drops without a transfer.
- Per-pixel arithmetic (8-bit channels, 10-bit intermediates):
  - Add: min(ch+value, 255).
  - Sub: max(ch-value, 0).
  - avg = floor((R+G+B)/3).
  - Invert: R=G=B=255-avg.
  - Threshold: R=G=B = (avg > threshold) ? 255 : 0; strict greater-than.
- Frame size: exactly WIDTH*HEIGHT/PPC transfers per frame. out_sol/out_eol are asserted on words 0 and WIDTH/PPC-1 of each line; both are asserted when WIDTH==PPC.
- Line gaps: HSYNC_DELAY counts from entry into HSYNC regardless of whether the previous line has drained. The buffer may still be emptying during the gap.
- Input changes: changes to mode, value or threshold while busy=1 have no effect until the next accepted start.
- start during ctrl_done cycle: ignored. A start in the following cycle is accepted.

Test Plan:
- WIDTH=8, HEIGHT=4, PPC=2, delays 3/2, mode 0, out_ready=1. Memory word k = k replicated in all channels.
  -> VSYNC high 3 cycles; 16 transfers with addresses 12..15, 8..11, 4..7, 0..3; ctrl_done 1 cycle after the 16th transfer.
- Mode 1, value=150, pixel R=200 G=50 B=105 -> {255,200,255}. Mode 2, value=150, same pixel -> {50,0,0}.
- Mode 3, pixel {10,20,31} (avg 20) -> {235,235,235}. Mode 4, threshold=90: avg 90 -> 0, avg 91 -> 255.
- Random out_ready (50% duty, seeded) over a full frame -> output sequence identical to the out_ready=1 run; out_data stable while stalled; no duplicated or dropped words.
- HRESETn=0 for 1 cycle during line 2 -> next cycle all outputs 0, state IDLE. A new start produces a complete, correct frame.
- start pulsed during DATA with a different mode -> ignored; the current frame completes in the original mode.

Source files
------------

// File: rtl/image_stream_src.sv
// Pixel source: reads a bottom-up RGB frame from synchronous memory, applies a
// selectable point operation and streams it out with valid/ready and sync framing.
module image_stream_src #(
   parameter int WIDTH          = 768,
   parameter int HEIGHT         = 512,
   parameter int PPC            = 2,
   parameter int START_UP_DELAY = 100,
   parameter int HSYNC_DELAY    = 160,
   parameter int ADDR_W         = 20
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   input  logic                start,
   input  logic [2:0]          mode,
   input  logic [7:0]          value,
   input  logic [7:0]          threshold,
   output logic                mem_rd,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic [PPC*24-1:0]   mem_rdata,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PPC*24-1:0]   out_data,
   output logic                out_sol,
   output logic                out_eol,
   output logic                VSYNC,
   output logic                HSYNC,
   output logic                busy,
   output logic                ctrl_done
);

   localparam int WPL     = WIDTH / PPC;
   localparam int DW      = PPC * 24;
   localparam int COL_W   = (WPL > 1) ? $clog2(WPL) : 1;
   localparam int LINE_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int DLY_MAX = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
   localparam int DLY_W   = $clog2(DLY_MAX + 1);
   localparam logic [ADDR_W-1:0] TOP_ADDR  = ADDR_W'((HEIGHT - 1) * WPL);
   localparam logic [ADDR_W-1:0] LINE_BACK = ADDR_W'(2 * WPL - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_VSYNC = 3'd1,
      S_HSYNC = 3'd2,
      S_DATA  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [DLY_W-1:0]    r_dly;
   logic [COL_W-1:0]    r_col;
   logic [LINE_W-1:0]   r_line;
   logic [ADDR_W-1:0]   r_addr;
   logic [2:0]          r_mode;
   logic [7:0]          r_value;
   logic [7:0]          r_thr;
   logic                r_rd_vld;
   logic                r_rd_sol;
   logic                r_rd_eol;
   logic [1:0][DW-1:0]  r_buf_data;
   logic [1:0]          r_buf_sol;
   logic [1:0]          r_buf_eol;
   logic                r_wp;
   logic                r_rp;
   logic [1:0]          r_occ;

   logic                w_start_ok;
   logic                w_pop;
   logic [1:0]          w_occ_after;
   logic                w_issue;
   logic                w_dly_done;
   logic                w_line_end;
   logic                w_frame_end;
   logic                w_drain_done;

   function automatic logic [7:0] f_add_sat(input logic [7:0] ch, input logic [7:0] v);
      logic [8:0] s;
      s = {1'b0, ch} + {1'b0, v};
      return s[8] ? 8'd255 : s[7:0];
   endfunction

   function automatic logic [7:0] f_sub_sat(input logic [7:0] ch, input logic [7:0] v);
      return (ch >= v) ? (ch - v) : 8'd0;
   endfunction

   function automatic logic [23:0] f_pix(input logic [2:0] m, input logic [7:0] v,
                                         input logic [7:0] t, input logic [23:0] px);
      logic [9:0]  sum;
      logic [9:0]  avg;
      logic [7:0]  y;
      logic [23:0] res;
      sum = {2'b00, px[23:16]} + {2'b00, px[15:8]} + {2'b00, px[7:0]};
      avg = sum / 10'd3;
      y   = 8'd0;
      res = px;
      case (m)
         3'd1: res = {f_add_sat(px[23:16], v), f_add_sat(px[15:8], v), f_add_sat(px[7:0], v)};
         3'd2: res = {f_sub_sat(px[23:16], v), f_sub_sat(px[15:8], v), f_sub_sat(px[7:0], v)};
         3'd3: begin
            y   = 8'd255 - avg[7:0];
            res = {y, y, y};
         end
         3'd4: begin
            y   = (avg > {2'b00, t}) ? 8'd255 : 8'd0;
            res = {y, y, y};
         end
         default: res = px;
      endcase
      return res;
   endfunction

   function automatic logic [DW-1:0] f_proc(input logic [2:0] m, input logic [7:0] v,
                                            input logic [7:0] t, input logic [DW-1:0] w);
      logic [DW-1:0] res;
      res = '0;
      for (int p = 0; p < PPC; p++) begin
         res[24*p +: 24] = f_pix(m, v, t, w[24*p +: 24]);
      end
      return res;
   endfunction

   assign w_start_ok   = (r_state == S_IDLE) && start;
   assign out_valid    = (r_occ != 2'd0);
   assign w_pop        = out_valid && out_ready;
   // Count this cycle's pop as free space so back-to-back reads keep 1 word/cycle.
   assign w_occ_after  = r_occ - {1'b0, w_pop};
   assign w_issue      = (r_state == S_DATA) && (({1'b0, w_occ_after} + {2'b00, r_rd_vld}) < 3'd2);
   assign w_dly_done   = ((r_state == S_VSYNC) && (r_dly == DLY_W'(START_UP_DELAY - 1))) ||
                         ((r_state == S_HSYNC) && (r_dly == DLY_W'(HSYNC_DELAY - 1)));
   assign w_line_end   = w_issue && (r_col == COL_W'(WPL - 1));
   assign w_frame_end  = w_line_end && (r_line == LINE_W'(HEIGHT - 1));
   assign w_drain_done = (r_state == S_DRAIN) && (r_occ == 2'd0) && !r_rd_vld;

   assign mem_rd    = w_issue;
   assign mem_addr  = r_addr;
   assign out_data  = r_buf_data[r_rp];
   assign out_sol   = r_buf_sol[r_rp];
   assign out_eol   = r_buf_eol[r_rp];
   assign VSYNC     = (r_state == S_VSYNC);
   assign HSYNC     = out_valid;
   assign busy      = (r_state != S_IDLE);
   assign ctrl_done = w_drain_done;

   // State register
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) w_next = S_VSYNC;
            else            w_next = S_IDLE;
         end
         S_VSYNC: begin
            if (w_dly_done) w_next = S_HSYNC;
            else            w_next = S_VSYNC;
         end
         S_HSYNC: begin
            if (w_dly_done) w_next = S_DATA;
            else            w_next = S_HSYNC;
         end
         S_DATA: begin
            if (w_frame_end)     w_next = S_DRAIN;
            else if (w_line_end) w_next = S_HSYNC;
            else                 w_next = S_DATA;
         end
         S_DRAIN: begin
            if (w_drain_done) w_next = S_IDLE;
            else              w_next = S_DRAIN;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Delay, position and address counters plus latched operation settings
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_dly    <= '0;
         r_col    <= '0;
         r_line   <= '0;
         r_addr   <= '0;
         r_mode   <= 3'd0;
         r_value  <= 8'd0;
         r_thr    <= 8'd0;
         r_rd_vld <= 1'b0;
         r_rd_sol <= 1'b0;
         r_rd_eol <= 1'b0;
      end else begin
         if (w_next != r_state)
            r_dly <= '0;
         else if ((r_state == S_VSYNC) || (r_state == S_HSYNC))
            r_dly <= r_dly + DLY_W'(1);
         else
            r_dly <= '0;

         if (w_start_ok)      r_col <= '0;
         else if (w_line_end) r_col <= '0;
         else if (w_issue)    r_col <= r_col + COL_W'(1);
         else                 r_col <= r_col;

         if (w_start_ok)                     r_line <= '0;
         else if (w_line_end && !w_frame_end) r_line <= r_line + LINE_W'(1);
         else                                r_line <= r_line;

         // Rows are stored bottom-up, so each new line steps back one row.
         if (w_start_ok)       r_addr <= TOP_ADDR;
         else if (w_frame_end) r_addr <= '0;
         else if (w_line_end)  r_addr <= r_addr - LINE_BACK;
         else if (w_issue)     r_addr <= r_addr + ADDR_W'(1);
         else                  r_addr <= r_addr;

         if (w_start_ok) begin
            r_mode  <= mode;
            r_value <= value;
            r_thr   <= threshold;
         end else begin
            r_mode  <= r_mode;
            r_value <= r_value;
            r_thr   <= r_thr;
         end

         r_rd_vld <= w_issue;
         r_rd_sol <= w_issue && (r_col == COL_W'(0));
         r_rd_eol <= w_issue && (r_col == COL_W'(WPL - 1));
      end
   end

   // Two-entry output buffer written with processed read data
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_buf_data <= '0;
         r_buf_sol  <= 2'b00;
         r_buf_eol  <= 2'b00;
         r_wp       <= 1'b0;
         r_rp       <= 1'b0;
         r_occ      <= 2'd0;
      end else begin
         if (r_rd_vld) begin
            r_buf_data[r_wp] <= f_proc(r_mode, r_value, r_thr, mem_rdata);
            r_buf_sol[r_wp]  <= r_rd_sol;
            r_buf_eol[r_wp]  <= r_rd_eol;
            r_wp             <= ~r_wp;
         end else begin
            r_wp <= r_wp;
         end
         if (w_pop) r_rp <= ~r_rp;
         else       r_rp <= r_rp;
         r_occ <= r_occ + {1'b0, r_rd_vld} - {1'b0, w_pop};
      end
   end

endmodule
